// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed scanner for a common-anode seven-segment display.
//   Each refresh tick from the upstream timer moves the scan to the next digit.
//   The display value, enables and decimal points are captured once per frame
//   (when the scan wraps back to digit 0), so a frame never mixes old and new data.
//
// Parameters
//   NUM_DIGITS   number of scanned digits, 2..8
//
// Ports
//   clk          system clock, rising edge
//   reset_n      synchronous, active-low reset
//   tick         one-cycle refresh strobe; advances the scan by one digit
//   value        hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   digit_en     per-digit enable (1 = may light)
//   dp_in        per-digit decimal point request (1 = lit)
//   AN           anode drives, active-low, at most one bit low
//   sseg         segments {g,f,e,d,c,b,a}, active-low
//   DP           decimal point, active-low
//   frame_start  registered one-cycle pulse when the scan wraps to digit 0
//
// Configuration
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits above digit 0 are
//                          blanked unless a decimal point is set at or above them.

module seven_seg_scanner #(
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tick,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              sseg,
  output logic                    DP,
  output logic                    frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] snap;
  logic [NUM_DIGITS-1:0]   snap_en;
  logic [NUM_DIGITS-1:0]   snap_dp;

  logic                    wrap;
  logic [3:0]              nibs [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              sseg_next;
  logic                    dp_next;

  // Active-low hex font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // The last digit's tick both wraps the scan and opens a new frame.
  assign wrap = tick && (idx == LAST_IDX);

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nibs[i] = snap[4*i +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the most significant digit; a digit stays blank only while
  // every digit from the top down to it is a zero without a decimal point.
  // Digit 0 is never blanked so a zero value still reads "0".
  always_comb begin
    logic run;
    blank = '0;
    run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run      = run && (snap[4*i +: 4] == 4'h0) && !snap_dp[i];
      blank[i] = run;
    end
  end
`else
  assign blank = '0;
`endif

  // Decode the currently selected digit from the frame snapshot.
  always_comb begin
    an_next   = '1;
    sseg_next = hex7(nibs[idx]);
    dp_next   = ~snap_dp[idx];
    if (snap_en[idx] && !blank[idx]) begin
      an_next = ~(ONE_HOT0 << idx);
    end
    if (blank[idx]) begin
      sseg_next = 7'h7F;
    end
  end

  // Scan index, frame snapshot and registered display outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx         <= '0;
      snap        <= '0;
      snap_en     <= '0;
      snap_dp     <= '0;
      AN          <= '1;
      sseg        <= 7'h7F;
      DP          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (tick) begin
        idx <= wrap ? '0 : idx + IDX_W'(1);
      end
      if (wrap) begin
        snap    <= value;
        snap_en <= digit_en;
        snap_dp <= dp_in;
      end
      AN   <= an_next;
      sseg <= sseg_next;
      DP   <= dp_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner
//   Bench for seven_seg_scanner with NUM_DIGITS=4. A vector table walks the
//   basic scan, the mid-frame value change and the enable/dp patterns; short
//   hand-written sequences cover leading-zero content, mid-frame reset and a
//   held tick; a random phase compares against a frame-level reference model.
//   Honours LEADING_ZERO_BLANK_EN the same way the design does.

module tb_seven_seg_scanner;

  localparam int N = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  // Segment pattern of a zero digit that the blanking rule may suppress.
  localparam logic [6:0] ZS = LZB ? 7'h7F : 7'h40;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic           clk;
  logic           reset_n;
  logic           tick;
  logic [4*N-1:0] value;
  logic [N-1:0]   digit_en;
  logic [N-1:0]   dp_in;
  logic [N-1:0]   AN;
  logic [6:0]     sseg;
  logic           DP;
  logic           frame_start;

  int checks   = 0;
  int failures = 0;

  // Reference model: digit position, frame snapshot and expected registered outputs.
  int          m_pos;
  logic [15:0] m_snap;
  logic [3:0]  m_en;
  logic [3:0]  m_dp;
  logic [12:0] m_out;

  typedef struct {
    logic        rst_n;
    logic        tck;
    logic [15:0] val;
    logic [3:0]  en;
    logic [3:0]  dp;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_fs;
  } vec_t;

  vec_t vecs [15];

  seven_seg_scanner #(.NUM_DIGITS(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .value       (value),
    .digit_en    (digit_en),
    .dp_in       (dp_in),
    .AN          (AN),
    .sseg        (sseg),
    .DP          (DP),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What the display should show for digit pos of a captured frame: {AN, sseg, DP}.
  function automatic logic [11:0] expect_display(input int pos, input logic [15:0] sv,
                                                 input logic [3:0] se, input logic [3:0] sd);
    logic [3:0] an;
    logic [6:0] seg;
    logic       blank;
    int         nib;
    nib   = int'((sv >> (4 * pos)) & 16'hF);
    blank = LZB && (pos > 0) && ((sv >> (4 * pos)) == 16'h0) && ((sd >> pos) == 4'h0);
    an    = (se[pos] && !blank) ? (4'hF & ~(4'b0001 << pos)) : 4'hF;
    seg   = blank ? 7'h7F : HEX_TAB[nib];
    return {an, seg, !sd[pos]};
  endfunction

  task automatic apply_stimulus(input logic r, input logic t, input logic [15:0] v,
                                input logic [3:0] e, input logic [3:0] d);
    reset_n  = r;
    tick     = t;
    value    = v;
    digit_en = e;
    dp_in    = d;
    @(posedge clk);
    if (!r) begin
      m_pos  = 0;
      m_snap = '0;
      m_en   = '0;
      m_dp   = '0;
      m_out  = {4'hF, 7'h7F, 1'b1, 1'b0};
    end else begin
      m_out = {expect_display(m_pos, m_snap, m_en, m_dp), (t && m_pos == N - 1)};
      if (t && m_pos == N - 1) begin
        m_snap = v;
        m_en   = e;
        m_dp   = d;
      end
      if (t) m_pos = (m_pos + 1) % N;
    end
    #1;
  endtask

  task automatic check_value(input string name, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_output(input string name, input logic [12:0] exp);
    check_value(name, {AN, sseg, DP, frame_start}, exp);
  endtask

  task automatic model_cycle(input string name, input logic r, input logic t,
                             input logic [15:0] v, input logic [3:0] e, input logic [3:0] d);
    apply_stimulus(r, t, v, e, d);
    check_output(name, m_out);
  endtask

  initial begin
    int fs_seen;
    logic r, t;
    logic [15:0] v;
    logic [3:0]  e, d;

    // rst, tick, value, en, dp -> AN, sseg, DP, frame_start
    vecs[0]  = '{1'b0, 1'b0, 16'h12AF, 4'hF, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 16'h12AF, 4'hF, 4'h0, 4'hF, 7'h40, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'h12AF, 4'hF, 4'h0, 4'hF, ZS,    1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 16'h12AF, 4'hF, 4'h0, 4'hF, ZS,    1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 16'h12AF, 4'hF, 4'h0, 4'hF, ZS,    1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 16'h12AF, 4'hF, 4'h0, 4'hF, ZS,    1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 16'h12AF, 4'hF, 4'h0, 4'hE, 7'h0E, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 16'h0000, 4'hF, 4'h0, 4'hE, 7'h0E, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 16'h0000, 4'hF, 4'h0, 4'hD, 7'h08, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 16'h0000, 4'hF, 4'h0, 4'hB, 7'h24, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 16'h0000, 4'h5, 4'h2, 4'h7, 7'h79, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 16'h0000, 4'h5, 4'h2, 4'hE, 7'h40, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 16'h0000, 4'h5, 4'h2, 4'hF, 7'h40, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 16'h0000, 4'h5, 4'h2, LZB ? 4'hF : 4'hB, ZS, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 16'h0000, 4'h5, 4'h2, 4'hF, ZS,    1'b1, 1'b0};

    $display("[TB] vector table");
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i].rst_n, vecs[i].tck, vecs[i].val, vecs[i].en, vecs[i].dp);
      check_output($sformatf("vec%0d", i),
                   {vecs[i].exp_an, vecs[i].exp_seg, vecs[i].exp_dp, vecs[i].exp_fs});
    end

    // Leading-zero content: scan sits on the last digit, one tick loads 0070.
    $display("[TB] leading zero sequence");
    model_cycle("lz_wrap", 1'b1, 1'b1, 16'h0070, 4'hF, 4'h0);
    apply_stimulus(1'b1, 1'b1, 16'h0070, 4'hF, 4'h0);
    check_output("lz_d0", {4'hE, 7'h40, 1'b1, 1'b0});
    apply_stimulus(1'b1, 1'b1, 16'h0070, 4'hF, 4'h0);
    check_output("lz_d1", {4'hD, 7'h78, 1'b1, 1'b0});
    apply_stimulus(1'b1, 1'b1, 16'h0070, 4'hF, 4'h0);
    check_output("lz_d2", {LZB ? 4'hF : 4'hB, ZS, 1'b1, 1'b0});
    apply_stimulus(1'b1, 1'b1, 16'h0000, 4'hF, 4'h0);
    check_output("lz_d3", {LZB ? 4'hF : 4'h7, ZS, 1'b1, 1'b1});
    apply_stimulus(1'b1, 1'b1, 16'h0000, 4'hF, 4'h0);
    check_output("zero_d0", {4'hE, 7'h40, 1'b1, 1'b0});
    apply_stimulus(1'b1, 1'b1, 16'h0000, 4'hF, 4'h0);
    check_output("zero_d1", {LZB ? 4'hF : 4'hD, ZS, 1'b1, 1'b0});

    // Reset while digit 2 is selected, then the scan restarts at digit 0.
    $display("[TB] mid-frame reset");
    apply_stimulus(1'b0, 1'b0, 16'h1234, 4'hF, 4'h0);
    check_output("rst_dark", {4'hF, 7'h7F, 1'b1, 1'b0});
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b1, 16'h1234, 4'hF, 4'h0);
      check_output($sformatf("rst_tick%0d", i), {4'hF, (i == 0) ? 7'h40 : ZS, 1'b1, 1'b0});
    end
    apply_stimulus(1'b1, 1'b1, 16'h1234, 4'hF, 4'h0);
    check_output("rst_wrap", {4'hF, ZS, 1'b1, 1'b1});
    apply_stimulus(1'b1, 1'b0, 16'h1234, 4'hF, 4'h0);
    check_output("rst_first", {4'hE, 7'h19, 1'b1, 1'b0});

    // Tick held high for eight cycles right after reset.
    $display("[TB] held tick");
    apply_stimulus(1'b0, 1'b0, 16'hBEEF, 4'hF, 4'h8);
    fs_seen = 0;
    for (int i = 0; i < 8; i++) begin
      model_cycle($sformatf("held%0d", i), 1'b1, 1'b1, 16'hBEEF, 4'hF, 4'h8);
      if (frame_start) fs_seen++;
    end
    check_value("held_fs_count", 13'(fs_seen), 13'd2);

    // Random phase against the reference model.
    $display("[TB] random phase");
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 59) != 0);
      t = ($urandom_range(0, 2) == 0);
      v = 16'($urandom);
      e = 4'($urandom);
      d = 4'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
      model_cycle($sformatf("rand%0d", i), r, t, v, e, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
